// File: rtl/ysyx_22050019_rd_arbiter.sv
// Two-master read arbiter: round-robin grant between icache (m0) and dcache (m1)
// onto a single AR/R bus, one outstanding transaction at a time.
module ysyx_22050019_rd_arbiter #(
    parameter int R_ADDR_WIDTH = 64,
    parameter int R_DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    // master 0: icache miss port
    input  logic                    m0_ar_valid_i,
    output logic                    m0_ar_ready_o,
    input  logic [R_ADDR_WIDTH-1:0] m0_ar_addr_i,
    output logic                    m0_r_valid_o,
    input  logic                    m0_r_ready_i,
    output logic [1:0]              m0_r_resp_o,
    output logic [R_DATA_WIDTH-1:0] m0_r_data_o,
    // master 1: dcache/LSU read port
    input  logic                    m1_ar_valid_i,
    output logic                    m1_ar_ready_o,
    input  logic [R_ADDR_WIDTH-1:0] m1_ar_addr_i,
    output logic                    m1_r_valid_o,
    input  logic                    m1_r_ready_i,
    output logic [1:0]              m1_r_resp_o,
    output logic [R_DATA_WIDTH-1:0] m1_r_data_o,
    // downstream bus
    output logic                    s_ar_valid_o,
    input  logic                    s_ar_ready_i,
    output logic [R_ADDR_WIDTH-1:0] s_ar_addr_o,
    input  logic                    s_r_valid_i,
    output logic                    s_r_ready_o,
    input  logic [1:0]              s_r_resp_i,
    input  logic [R_DATA_WIDTH-1:0] s_r_data_i
);
    typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_e;

    state_e                  state_q, state_d;
    logic                    last_q, last_d;
    logic                    gnt_q, gnt_d;
    logic                    ar_valid_q, ar_valid_d;
    logic [R_ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;

    logic any_req, sel, in_idle, in_r, r0_sel, r1_sel;

    assign any_req = m0_ar_valid_i | m1_ar_valid_i;
    // On a tie the master that did not win last time is picked.
    assign sel     = (m0_ar_valid_i & m1_ar_valid_i) ? ~last_q : m1_ar_valid_i;
    assign in_idle = ~rst & (state_q == S_IDLE);
    assign in_r    = ~rst & (state_q == S_R);
    assign r0_sel  = in_r & ~gnt_q;
    assign r1_sel  = in_r & gnt_q;

    assign m0_ar_ready_o = in_idle & any_req & ~sel;
    assign m1_ar_ready_o = in_idle & any_req & sel;

    assign s_r_ready_o  = (r0_sel & m0_r_ready_i) | (r1_sel & m1_r_ready_i);
    assign m0_r_valid_o = r0_sel & s_r_valid_i;
    assign m1_r_valid_o = r1_sel & s_r_valid_i;
    assign m0_r_data_o  = r0_sel ? s_r_data_i : '0;
    assign m1_r_data_o  = r1_sel ? s_r_data_i : '0;
    assign m0_r_resp_o  = r0_sel ? s_r_resp_i : 2'b00;
    assign m1_r_resp_o  = r1_sel ? s_r_resp_i : 2'b00;

    assign s_ar_valid_o = ar_valid_q;
    assign s_ar_addr_o  = ar_addr_q;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        ar_valid_d = ar_valid_q;
        ar_addr_d  = ar_addr_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    gnt_d      = sel;
                    ar_addr_d  = sel ? m1_ar_addr_i : m0_ar_addr_i;
                    ar_valid_d = 1'b1;
                    state_d    = S_AR;
                end
            end
            S_AR: begin
                if (ar_valid_q && s_ar_ready_i) begin
                    ar_valid_d = 1'b0;
                    state_d    = S_R;
                end
            end
            S_R: begin
                if (s_r_valid_i && s_r_ready_o) begin
                    last_d  = gnt_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_q     <= 1'b1;
            gnt_q      <= 1'b0;
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            ar_valid_q <= ar_valid_d;
            ar_addr_q  <= ar_addr_d;
        end
    end
endmodule

// File: tb/tb_ysyx_22050019_rd_arbiter.sv
// Bench for the two-master read arbiter: vector table of request patterns,
// scoreboard of expected bus transactions, plus reset/idle corner sequences.
module tb_ysyx_22050019_rd_arbiter;
    logic        clk, rst;
    logic        m0_ar_valid_i, m0_ar_ready_o, m0_r_valid_o, m0_r_ready_i;
    logic [63:0] m0_ar_addr_i, m0_r_data_o;
    logic [1:0]  m0_r_resp_o;
    logic        m1_ar_valid_i, m1_ar_ready_o, m1_r_valid_o, m1_r_ready_i;
    logic [63:0] m1_ar_addr_i, m1_r_data_o;
    logic [1:0]  m1_r_resp_o;
    logic        s_ar_valid_o, s_ar_ready_i, s_r_valid_i, s_r_ready_o;
    logic [63:0] s_ar_addr_o, s_r_data_i;
    logic [1:0]  s_r_resp_i;

    ysyx_22050019_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_ar_valid_i(m0_ar_valid_i), .m0_ar_ready_o(m0_ar_ready_o), .m0_ar_addr_i(m0_ar_addr_i),
        .m0_r_valid_o(m0_r_valid_o), .m0_r_ready_i(m0_r_ready_i), .m0_r_resp_o(m0_r_resp_o),
        .m0_r_data_o(m0_r_data_o),
        .m1_ar_valid_i(m1_ar_valid_i), .m1_ar_ready_o(m1_ar_ready_o), .m1_ar_addr_i(m1_ar_addr_i),
        .m1_r_valid_o(m1_r_valid_o), .m1_r_ready_i(m1_r_ready_i), .m1_r_resp_o(m1_r_resp_o),
        .m1_r_data_o(m1_r_data_o),
        .s_ar_valid_o(s_ar_valid_o), .s_ar_ready_i(s_ar_ready_i), .s_ar_addr_o(s_ar_addr_o),
        .s_r_valid_i(s_r_valid_i), .s_r_ready_o(s_r_ready_o), .s_r_resp_i(s_r_resp_i),
        .s_r_data_i(s_r_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        m;
        logic [63:0] a;
        logic [63:0] d;
        logic [1:0]  r;
    } exp_t;

    typedef struct {
        logic        v0;
        logic [63:0] a0;
        logic        v1;
        logic [63:0] a1;
        int          arw;
        int          rw;
        logic [63:0] d0;
        logic [1:0]  r0;
        logic [63:0] d1;
        logic [1:0]  r1;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[8];
    int   total = 0;
    int   bad = 0;
    logic mdl_last;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: address at AR handshake, data/resp/id at R handshake.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ar_ready", 64'({m0_ar_ready_o, m1_ar_ready_o}), 64'd0);
            chk("rst_r_valid", 64'({m0_r_valid_o, m1_r_valid_o}), 64'd0);
            chk("rst_s_r_ready", 64'(s_r_ready_o), 64'd0);
        end else begin
            chk("dual_grant", 64'(m0_ar_ready_o & m1_ar_ready_o), 64'd0);
            if (s_ar_valid_o && s_ar_ready_i) begin
                chk("sb_ar_pending", 64'(sbq.size() != 0), 64'd1);
                if (sbq.size() != 0) chk("sb_ar_addr", s_ar_addr_o, sbq[0].a);
            end
            if ((m0_r_valid_o && m0_r_ready_i) || (m1_r_valid_o && m1_r_ready_i)) begin
                chk("sb_r_pending", 64'(sbq.size() != 0), 64'd1);
                if (sbq.size() != 0) begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("sb_r_master", 64'(m1_r_valid_o), 64'(e.m));
                    chk("sb_r_data", m1_r_valid_o ? m1_r_data_o : m0_r_data_o, e.d);
                    chk("sb_r_resp", 64'(m1_r_valid_o ? m1_r_resp_o : m0_r_resp_o), 64'(e.r));
                    chk("sb_r_other_quiet",
                        e.m ? (m0_r_data_o | 64'(m0_r_resp_o) | 64'(m0_r_valid_o))
                            : (m1_r_data_o | 64'(m1_r_resp_o) | 64'(m1_r_valid_o)), 64'd0);
                    chk("sb_s_r_ready", 64'(s_r_ready_o), 64'd1);
                end
            end
        end
    end

    // Plays the bus slave and the granted master for the transaction at the scoreboard head.
    task automatic serve(input int arw, input int rw);
        exp_t e;
        int   n;
        e = sbq[0];
        n = 0;
        @(negedge clk);
        while (!(e.m ? m1_ar_ready_o : m0_ar_ready_o) && n < 16) begin
            n++;
            @(negedge clk);
        end
        chk("grant_latency", 64'(n), 64'd0);
        chk("grant_other", 64'(e.m ? m0_ar_ready_o : m1_ar_ready_o), 64'd0);
        @(posedge clk); #1;
        if (e.m) m1_ar_valid_i = 1'b0; else m0_ar_valid_i = 1'b0;
        for (int i = 0; i <= arw; i++) begin
            if (i == arw) s_ar_ready_i = 1'b1;
            @(negedge clk);
            chk("ar_hold_off", 64'({m0_ar_ready_o, m1_ar_ready_o}), 64'd0);
            chk("s_ar_valid", 64'(s_ar_valid_o), 64'd1);
            chk("s_ar_addr", s_ar_addr_o, e.a);
            @(posedge clk); #1;
        end
        s_ar_ready_i = 1'b0;
        s_r_valid_i  = 1'b1;
        s_r_data_i   = e.d;
        s_r_resp_i   = e.r;
        for (int i = 0; i <= rw; i++) begin
            m0_r_ready_i = e.m ? 1'b1 : (i == rw);
            m1_r_ready_i = e.m ? (i == rw) : 1'b1;
            @(negedge clk);
            chk("s_ar_valid_low_r", 64'(s_ar_valid_o), 64'd0);
            chk("s_r_ready", 64'(s_r_ready_o), 64'(i == rw));
            chk("r_valid_fwd", 64'(e.m ? m1_r_valid_o : m0_r_valid_o), 64'd1);
            chk("ar_hold_off_r", 64'({m0_ar_ready_o, m1_ar_ready_o}), 64'd0);
            @(posedge clk); #1;
        end
        s_r_valid_i  = 1'b0;
        m0_r_ready_i = 1'b0;
        m1_r_ready_i = 1'b0;
        s_r_data_i   = {$urandom, $urandom};
        s_r_resp_i   = 2'b00;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e0, e1;
        int   n;
        e0 = '{1'b0, v.a0, v.d0, v.r0};
        e1 = '{1'b1, v.a1, v.d1, v.r1};
        n  = 0;
        if (v.v0 && v.v1) begin
            if (mdl_last) begin sbq.push_back(e0); sbq.push_back(e1); end
            else          begin sbq.push_back(e1); sbq.push_back(e0); end
            n = 2;
        end else if (v.v0) begin
            sbq.push_back(e0); mdl_last = 1'b0; n = 1;
        end else if (v.v1) begin
            sbq.push_back(e1); mdl_last = 1'b1; n = 1;
        end
        m0_ar_valid_i = v.v0; m0_ar_addr_i = v.a0;
        m1_ar_valid_i = v.v1; m1_ar_addr_i = v.a1;
        repeat (n) serve(v.arw, v.rw);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        m0_ar_valid_i = 1'b1; m0_ar_addr_i = 64'h55; m0_r_ready_i = 1'b1;
        m1_ar_valid_i = 1'b1; m1_ar_addr_i = 64'h66; m1_r_ready_i = 1'b1;
        s_ar_ready_i = 1'b1; s_r_valid_i = 1'b1; s_r_resp_i = 2'b10; s_r_data_i = 64'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        m0_ar_valid_i = 1'b0; m1_ar_valid_i = 1'b0; m0_r_ready_i = 1'b0; m1_r_ready_i = 1'b0;
        s_ar_ready_i = 1'b0; s_r_valid_i = 1'b0; s_r_resp_i = 2'b00;
        @(negedge clk);
        chk("rst_s_ar_valid", 64'(s_ar_valid_o), 64'd0);
        chk("rst_s_ar_addr", s_ar_addr_o, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mdl_last = 1'b1;

        vecs[0] = '{1'b1, 64'h1000, 1'b1, 64'h2000, 0, 0, 64'hA0A0_0000_0000_0001, 2'b00, 64'hB1B1_0000_0000_0002, 2'b00};
        vecs[1] = '{1'b1, 64'h1040, 1'b1, 64'h2040, 0, 0, 64'hA0A0_0000_0000_0003, 2'b00, 64'hB1B1_0000_0000_0004, 2'b00};
        vecs[2] = '{1'b1, 64'h8000_0040, 1'b0, 64'h0, 0, 0, 64'h1122_3344_5566_7788, 2'b00, 64'h0, 2'b00};
        vecs[3] = '{1'b0, 64'h0, 1'b1, 64'h2000_0000_DEAD_BEEF, 4, 0, 64'h0, 2'b00, 64'hCAFE_F00D_1234_5678, 2'b00};
        vecs[4] = '{1'b1, 64'h3000, 1'b0, 64'h0, 0, 3, 64'h0BAD_C0DE_0000_0033, 2'b00, 64'h0, 2'b00};
        vecs[5] = '{1'b0, 64'h0, 1'b1, 64'h4000, 0, 0, 64'h0, 2'b00, 64'h7777_0000_8888_0000, 2'b10};
        vecs[6] = '{1'b1, 64'h5000, 1'b0, 64'h0, 1, 0, 64'h0123_4567_89AB_CDEF, 2'b00, 64'h0, 2'b00};
        vecs[7] = '{1'b1, 64'h6000, 1'b1, 64'h7000, 2, 1, 64'hAAAA_5555_AAAA_5555, 2'b01, 64'h5555_AAAA_5555_AAAA, 2'b11};
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Stray read data while idle must not reach either master.
        s_r_valid_i = 1'b1; s_r_data_i = 64'hDEAD_DEAD_DEAD_DEAD; s_r_resp_i = 2'b11;
        m0_r_ready_i = 1'b1; m1_r_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("idle_r_valid", 64'({m0_r_valid_o, m1_r_valid_o}), 64'd0);
            chk("idle_s_r_ready", 64'(s_r_ready_o), 64'd0);
            chk("idle_r_data", m0_r_data_o | m1_r_data_o | 64'(m0_r_resp_o) | 64'(m1_r_resp_o), 64'd0);
            @(posedge clk); #1;
        end
        s_r_valid_i = 1'b0; m0_r_ready_i = 1'b0; m1_r_ready_i = 1'b0;

        // Reset while m1's transaction sits in the read phase.
        sbq.push_back('{1'b1, 64'h9000, 64'h9999, 2'b00});
        m1_ar_valid_i = 1'b1; m1_ar_addr_i = 64'h9000;
        @(posedge clk); #1;
        m1_ar_valid_i = 1'b0; s_ar_ready_i = 1'b1;
        @(posedge clk); #1;
        s_ar_ready_i = 1'b0; s_r_valid_i = 1'b1; s_r_data_i = 64'h9999;
        m0_r_ready_i = 1'b1; m1_r_ready_i = 1'b0;
        @(negedge clk);
        chk("pre_rst_r_valid", 64'(m1_r_valid_o), 64'd1);
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        void'(sbq.pop_front());
        mdl_last = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ar_valid", 64'(s_ar_valid_o), 64'd0);
        chk("post_rst_r_valid", 64'({m0_r_valid_o, m1_r_valid_o}), 64'd0);
        chk("post_rst_s_r_ready", 64'(s_r_ready_o), 64'd0);
        chk("post_rst_r_data", m1_r_data_o, 64'd0);
        @(posedge clk); #1;
        s_r_valid_i = 1'b0; m0_r_ready_i = 1'b0;
        run_vec('{1'b1, 64'hA000, 1'b1, 64'hB000, 0, 0, 64'h0A0A, 2'b00, 64'h0B0B, 2'b00});

        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
